uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the downstream partner of the existing UART transmitter. It consumes the serial line that the transmitter's TX_OUT drives, and recovers the parallel byte. It checks the optional parity bit and the stop bit, then presents the byte with a one-cycle valid strobe. The receiver is oversampled: the receive clock runs at Prescale times the bit rate.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first.
PRESCALE_W, 6, width of the Prescale input and of the edge counter.

Ports:
CLK  input  1  receive clock (Prescale x bit rate)
RST_ASYN  input  1  reset; asynchronous, active-low
RX_IN  input  1  serial line; idles high
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
Prescale  input  PRESCALE_W  clocks per bit; legal values are even, 8..32
P_DATA  output  DATA_BITS  received byte
Data_Valid  output  1  one-cycle strobe; P_DATA is good
PAR_ERR  output  1  one-cycle strobe; parity mismatch
STP_ERR  output  1  one-cycle strobe; stop bit sampled 0
busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset values: P_DATA=0, Data_Valid=0, PAR_ERR=0, STP_ERR=0, busy=0. FSM in IDLE, counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is produced.
- RX_IN passes through a 2-flop synchronizer; rx_s is the synchronized value. All decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: when rx_s=0, go to START, clear edge_cnt, set busy=1. Prescale, PAR_EN and PAR_TYP are latched at this point. Changing these inputs mid-frame has no effect.
- edge_cnt counts 0..P-1 once per bit period, where P is the latched Prescale. The sample point is edge_cnt == P/2-1. The bit ends at edge_cnt == P-1.
- START: sample at the sample point. If the sample is 1, treat it as a glitch: return to IDLE next cycle, busy=0, no strobes. If the sample is 0, go to DATA at the end of the bit.
- DATA: sample DATA_BITS bits, LSB first, into a shift register. After the last bit, go to PARITY if PAR_EN=1, otherwise to STOP.
- PARITY: expected bit = ^data when PAR_TYP=0, ~^data when PAR_TYP=1. This matches the transmitter's encoding. Record a mismatch flag.
- STOP: at the sample point, record a stop error if the sample is 0. Go to DONE on the next cycle; do not wait for the end of the bit. This leaves half a bit of margin for back-to-back frames.
- DONE (exactly 1 cycle):
  - No errors: P_DATA <= shift register and Data_Valid=1.
  - Otherwise: PAR_ERR and/or STP_ERR =1. P_DATA and Data_Valid are left unchanged.
  - Next state is IDLE, busy=0.
- P_DATA holds its value until the next good frame.
- A start bit arriving in the cycle after DONE is detected normally, so there is no dead time beyond one cycle.
- Latency: Data_Valid rises (sync 2) + (1 + DATA_BITS + PAR_EN)·P + P/2 + 1 cycles after the RX_IN falling edge. Benches check within ±1 cycle.
- Illegal Prescale (odd, below 8, or above 32) gives undefined data, but the FSM must still return to IDLE.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each bit is the majority of the three samples taken at edge_cnt = P/2-2, P/2-1 and P/2. This applies to the start, data, parity and stop bits.
- Undefined: a single sample is taken at P/2-1.
- Timing of strobes and state transitions is identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding
  - PAR_EVEN = 0 and PAR_ODD = 1
  - minimum/maximum Prescale constants
  - default DATA_BITS
- One sub-module, uart_rx_sampler, holds edge_cnt, bit_cnt and the sample/majority logic. It outputs sample_valid, sampled_bit and bit_done. The FSM and data/parity/stop checking stay in the top.

Test Plan:
- No parity, Prescale=8: the TX frame for 8'b11011001 → P_DATA=0xD9, one Data_Valid pulse, PAR_ERR=STP_ERR=0, busy drops within 1 cycle of DONE.
- PAR_EN=1, PAR_TYP=0, data 0xD9, parity bit 1 → Data_Valid. Same frame with PAR_TYP=1 → PAR_ERR pulse, no Data_Valid, P_DATA keeps 0xD9.
- Stop bit forced 0 on frame 0x3C → STP_ERR pulse, no Data_Valid.
- Glitch: RX_IN low for 2 cycles at Prescale=16 → no strobes, busy returns to 0, next valid frame 0xA5 is received correctly.
- Back-to-back frames 0x55 then 0xAA with no idle gap, at Prescale=16 and 32 → two Data_Valid pulses with correct data.
- RST_ASYN pulsed low mid-DATA → outputs reset immediately, no strobe; a following frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM encoding, parity types, Prescale limits.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} rx_state_e;

  localparam logic PAR_EVEN      = 1'b0;
  localparam logic PAR_ODD       = 1'b1;
  localparam int   PRESCALE_MIN  = 8;
  localparam int   PRESCALE_MAX  = 32;
  localparam int   DEF_DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame config in, recovered byte and strobes out.
interface uart_rx_if #(
  parameter int DATA_BITS  = uart_pkg::DEF_DATA_BITS,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_BITS-1:0]  P_DATA;
  logic                  Data_Valid;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  busy;

  modport master (output RX_IN, PAR_EN, PAR_TYP, Prescale,
                  input  P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy);
  modport slave  (input  RX_IN, PAR_EN, PAR_TYP, Prescale,
                  output P_DATA, Data_Valid, PAR_ERR, STP_ERR, busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: edge/bit counters and mid-bit sampling.
// UART_RX_MAJORITY_EN selects a 3-sample majority vote around the bit centre.
module uart_rx_sampler import uart_pkg::*; #(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  rx_s,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sample_valid,
  output logic                  sampled_bit,
  output logic                  bit_done,
  output logic [CNT_W-1:0]      bit_cnt
);
  logic [PRESCALE_W-1:0] edge_cnt, half, last;
  logic                  s1;

  assign half = prescale >> 1;
  assign last = prescale - PRESCALE_W'(1);

  // Decision is presented at P/2 in both builds so strobe timing never depends on the macro.
  assign sample_valid = en && (edge_cnt == half);
  assign bit_done     = en && (edge_cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == last) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       s1 <= 1'b1;
    else if (en && edge_cnt == half - PRESCALE_W'(1)) s1 <= rx_s;
  end

`ifdef UART_RX_MAJORITY_EN
  logic s0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       s0 <= 1'b1;
    else if (en && edge_cnt == half - PRESCALE_W'(2)) s0 <= rx_s;
  end
  assign sampled_bit = maj3(s0, s1, rx_s);
`else
  assign sampled_bit = s1;
`endif
endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: sync, frame FSM, parity/stop checks, one-cycle strobes.
// Build option UART_RX_MAJORITY_EN enables majority-vote bit sampling (see uart_rx_sampler).
module uart_rx import uart_pkg::*; #(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PRESCALE_W = 6
) (
  input logic      CLK,
  input logic      RST_ASYN,
  uart_rx_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_BITS + 3);

  rx_state_e             state;
  logic [1:0]            sync;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] prescale_l;
  logic                  par_en_l, par_typ_l, par_bad, exp_par;
  logic [DATA_BITS-1:0]  sr;
  logic                  en, sample_valid, sampled_bit, bit_done;
  logic [CNT_W-1:0]      bit_cnt;

  assign rx_s    = sync[1];
  assign en      = (state != IDLE) && (state != DONE);
  assign exp_par = (par_typ_l == PAR_ODD) ? ~^sr : ^sr;

  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) sync <= 2'b11;
    else           sync <= {sync[0], bus.RX_IN};
  end

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W), .CNT_W(CNT_W)) u_sampler (
    .clk          (CLK),
    .rst_n        (RST_ASYN),
    .en           (en),
    .rx_s         (rx_s),
    .prescale     (prescale_l),
    .sample_valid (sample_valid),
    .sampled_bit  (sampled_bit),
    .bit_done     (bit_done),
    .bit_cnt      (bit_cnt)
  );

  always_ff @(posedge CLK or negedge RST_ASYN) begin
    if (!RST_ASYN) begin
      state          <= IDLE;
      prescale_l     <= '0;
      par_en_l       <= 1'b0;
      par_typ_l      <= 1'b0;
      par_bad        <= 1'b0;
      sr             <= '0;
      bus.P_DATA     <= '0;
      bus.Data_Valid <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.Data_Valid <= 1'b0;
      bus.PAR_ERR    <= 1'b0;
      bus.STP_ERR    <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state      <= START;
          bus.busy   <= 1'b1;
          prescale_l <= bus.Prescale;
          par_en_l   <= bus.PAR_EN;
          par_typ_l  <= bus.PAR_TYP;
          par_bad    <= 1'b0;
        end
        START: begin
          if (sample_valid && sampled_bit) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (bit_done) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (sample_valid) sr <= {sampled_bit, sr[DATA_BITS-1:1]};
          if (bit_done && bit_cnt == CNT_W'(DATA_BITS)) state <= par_en_l ? PARITY : STOP;
        end
        PARITY: begin
          if (sample_valid) par_bad <= (sampled_bit != exp_par);
          if (bit_done)     state   <= STOP;
        end
        // Strobes are registered on the way into DONE so they are high exactly during DONE.
        STOP: if (sample_valid) begin
          state <= DONE;
          if (!sampled_bit || par_bad) begin
            bus.PAR_ERR <= par_bad;
            bus.STP_ERR <= !sampled_bit;
          end else begin
            bus.P_DATA     <= sr;
            bus.Data_Valid <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built serial frames, strobe counting, latency window.
module tb_uart_rx;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8), .PRESCALE_W(6)) bus ();
  uart_rx    #(.DATA_BITS(8), .PRESCALE_W(6)) dut (.CLK(clk), .RST_ASYN(rst_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dv_cyc = 0;
  logic [7:0] last_d = 8'h00, prev_d = 8'h00;
  logic prev_dv = 1'b0, busy_after_dv = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_dv) busy_after_dv = bus.busy;
    prev_dv = bus.Data_Valid;
    if (bus.Data_Valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      prev_d = last_d;
      last_d = bus.P_DATA;
    end
    if (bus.PAR_ERR) pe_cnt++;
    if (bus.STP_ERR) se_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int p, input logic pen, input logic ptyp);
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
  endtask

  task automatic send(input logic [7:0] d, input int p, input logic pen,
                      input logic pbit, input logic stp);
    bus.RX_IN = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX_IN = d[i];
      repeat (p) @(negedge clk);
    end
    if (pen) begin
      bus.RX_IN = pbit;
      repeat (p) @(negedge clk);
    end
    bus.RX_IN = stp;
    repeat (p) @(negedge clk);
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    int b_dv, b_pe, b_se, t0, d;
    bus.RX_IN = 1'b1;
    cfg(8, 1'b0, 1'b0);
    idle(3);
    chk("rst_pdata", bus.P_DATA, 8'h00);
    chk("rst_dv",    bus.Data_Valid, 1'b0);
    chk("rst_pe",    bus.PAR_ERR, 1'b0);
    chk("rst_se",    bus.STP_ERR, 1'b0);
    chk("rst_busy",  bus.busy, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // plain 8N1 frame; expected latency 2 + 9*8 + 4 + 1 = 79 cycles
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; t0 = cyc;
    send(8'hD9, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("t1_dv",    dv_cnt - b_dv, 1);
    chk("t1_data",  bus.P_DATA, 8'hD9);
    chk("t1_pe",    pe_cnt - b_pe, 0);
    chk("t1_se",    se_cnt - b_se, 0);
    d = (dv_cyc - t0) - 79;
    chk("t1_lat",   (d >= -1 && d <= 1), 1);
    chk("t1_busy",  busy_after_dv, 1'b0);

    // even parity, 0xD9 has five ones -> parity bit 1
    cfg(8, 1'b1, 1'b0);
    b_dv = dv_cnt; b_pe = pe_cnt;
    send(8'hD9, 8, 1'b1, 1'b1, 1'b1);
    idle(6);
    chk("t2_dv",   dv_cnt - b_dv, 1);
    chk("t2_data", bus.P_DATA, 8'hD9);
    chk("t2_pe",   pe_cnt - b_pe, 0);

    // same line, odd parity expected -> mismatch
    cfg(8, 1'b1, 1'b1);
    b_dv = dv_cnt; b_pe = pe_cnt;
    send(8'hD9, 8, 1'b1, 1'b1, 1'b1);
    idle(6);
    chk("t3_pe",   pe_cnt - b_pe, 1);
    chk("t3_dv",   dv_cnt - b_dv, 0);
    chk("t3_data", bus.P_DATA, 8'hD9);

    // stop bit forced low
    cfg(8, 1'b0, 1'b0);
    b_dv = dv_cnt; b_se = se_cnt;
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    idle(30);
    chk("t4_se",   se_cnt - b_se, 1);
    chk("t4_dv",   dv_cnt - b_dv, 0);
    chk("t4_data", bus.P_DATA, 8'hD9);
    chk("t4_busy", bus.busy, 1'b0);

    // 2-cycle glitch at Prescale=16, then a real frame
    cfg(16, 1'b0, 1'b0);
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    bus.RX_IN = 1'b0;
    idle(2);
    bus.RX_IN = 1'b1;
    idle(40);
    chk("t5_strobes", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se), 0);
    chk("t5_busy",    bus.busy, 1'b0);
    send(8'hA5, 16, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("t5_data", bus.P_DATA, 8'hA5);
    chk("t5_dv",   dv_cnt - b_dv, 1);

    // back-to-back frames with no idle gap
    for (int k = 0; k < 2; k++) begin
      int p;
      p = (k == 0) ? 16 : 32;
      cfg(p, 1'b0, 1'b0);
      b_dv = dv_cnt;
      send(8'h55, p, 1'b0, 1'b0, 1'b1);
      send(8'hAA, p, 1'b0, 1'b0, 1'b1);
      idle(8);
      chk("t6_dv",    dv_cnt - b_dv, 2);
      chk("t6_first", prev_d, 8'h55);
      chk("t6_second", last_d, 8'hAA);
    end

    // async reset in the middle of the data bits
    cfg(8, 1'b0, 1'b0);
    b_dv = dv_cnt;
    bus.RX_IN = 1'b0; idle(8);
    bus.RX_IN = 1'b1; idle(8);
    bus.RX_IN = 1'b0; idle(4);
    chk("t7_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t7_busy",  bus.busy, 1'b0);
    chk("t7_pdata", bus.P_DATA, 8'h00);
    chk("t7_dvrst", bus.Data_Valid, 1'b0);
    @(negedge clk);
    bus.RX_IN = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    chk("t7_nostrobe", dv_cnt - b_dv, 0);
    send(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("t7_data", bus.P_DATA, 8'h0F);
    chk("t7_dv",   dv_cnt - b_dv, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
